// File: rtl/stream_demux_n.sv
// Packet-aware 1:N stream demultiplexer with one registered slot per channel.
// The channel is locked on the first beat; invalid selects are dropped and counted.
module stream_demux_n #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = $clog2(N_OUT),
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_e;

    state_e                    state_q;
    logic [SEL_W-1:0]          ch_q;
    logic [N_OUT-1:0]          valid_q, valid_d;
    logic [N_OUT-1:0]          last_q, last_d;
    logic [N_OUT*DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]          cnt_q;
    logic                      pulse_q;

    logic [N_OUT-1:0] free, sel_hit, ch_hit, wr;
    logic             sel_ok, sel_free, ch_free;
    logic             rdy, acc, drop_last;

    always_comb begin
        free     = ~valid_q | out_ready;
        sel_hit  = '0;
        ch_hit   = '0;
        sel_ok   = 1'b0;
        sel_free = 1'b0;
        ch_free  = 1'b0;
        // Per-channel decode keeps out-of-range selects from ever matching
        for (int k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (in_sel == SEL_W'(k));
            ch_hit[k]  = (ch_q == SEL_W'(k));
            sel_ok     = sel_ok | sel_hit[k];
            sel_free   = sel_free | (sel_hit[k] & free[k]);
            ch_free    = ch_free | (ch_hit[k] & free[k]);
        end
        rdy = 1'b0;
        wr  = '0;
        unique case (state_q)
            IDLE: begin
                rdy = sel_ok ? sel_free : 1'b1;
                wr  = sel_hit;
            end
            ROUTE: begin
                rdy = ch_free;
                wr  = ch_hit;
            end
            DROP:    rdy = 1'b1;
            default: rdy = 1'b0;
        endcase
        rdy       = rdy & ~rst;
        acc       = in_valid & rdy;
        wr        = wr & {N_OUT{acc}};
        drop_last = acc & in_last &
                    (((state_q == IDLE) & ~sel_ok) | (state_q == DROP));
    end

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (wr[k]) begin
                valid_d[k]                   = 1'b1;
                last_d[k]                    = in_last;
                data_d[k*DATA_W +: DATA_W]   = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k]                   = 1'b0;
                last_d[k]                    = 1'b0;
                data_d[k*DATA_W +: DATA_W]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            valid_q <= '0;
            last_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            pulse_q <= drop_last;
            if (drop_last && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
            if (acc) begin
                unique case (state_q)
                    IDLE: begin
                        if (sel_ok) begin
                            ch_q <= in_sel;
                            if (!in_last) state_q <= ROUTE;
                        end else if (!in_last) begin
                            state_q <= DROP;
                        end
                    end
                    ROUTE, DROP: if (in_last) state_q <= IDLE;
                    default:     state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready   = rdy;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign out_valid  = valid_q;
    assign drop_pulse = pulse_q;
    assign drop_cnt   = cnt_q;

endmodule
